mem_stage_lsu: RTL and testbench

MEM_STAGE_LSU -- requirements
Module: mem_stage_lsu

---
 rtl/mem_stage_pkg.sv | 58 +++++
 rtl/dmem_bank.sv | 26 ++
 rtl/mem_stage_lsu.sv | 109 ++++++++++
 tb/tb_mem_stage_lsu.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - Funct3 encodings, access sizing, lane-mask and load-extend helpers for mem_stage_lsu
package mem_stage_pkg;

   localparam int XLEN_DEF = 32;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef enum logic [1:0] {
      SZ_BYTE,
      SZ_HALF,
      SZ_WORD
   } accSize_t;

   // Any code that is not a byte or halfword access is handled as a full word
   function automatic accSize_t accSize(input logic [2:0] funct3);
      case (funct3)
         F3_B, F3_BU: return SZ_BYTE;
         F3_H, F3_HU: return SZ_HALF;
         default:     return SZ_WORD;
      endcase
   endfunction

   // Byte lanes touched by a store of the given size at the given lane
   function automatic logic [3:0] laneMask(input accSize_t size, input logic [1:0] lane);
      case (size)
         SZ_BYTE: return 4'b0001 << lane;
         SZ_HALF: return lane[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   // Select the addressed byte/halfword out of the word and sign- or zero-extend it
   function automatic logic [XLEN_DEF-1:0] extendLoad(input logic [2:0] funct3,
                                                      input logic [XLEN_DEF-1:0] word,
                                                      input logic [1:0] lane);
      logic [7:0]  b;
      logic [15:0] h;
      case (lane)
         2'd0:    b = word[7:0];
         2'd1:    b = word[15:8];
         2'd2:    b = word[23:16];
         default: b = word[31:24];
      endcase
      h = lane[1] ? word[31:16] : word[15:0];
      case (funct3)
         F3_B:    return {{24{b[7]}}, b};
         F3_BU:   return {24'b0, b};
         F3_H:    return {{16{h[15]}}, h};
         F3_HU:   return {16'b0, h};
         default: return word;
      endcase
   endfunction

endpackage

// File: rtl/dmem_bank.sv
// rtl/dmem_bank.sv - byte-lane data array, combinational read, per-lane write enables
module dmem_bank #(
   parameter int DEPTH = 1024,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic [AW-1:0] addr,
   input  logic [3:0]    we,
   input  logic [31:0]   wdata,
   output logic [31:0]   rdata
);

   logic [3:0][7:0] mem [DEPTH];

   // Write only the enabled lanes; contents are never reset
   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (we[i]) begin
            mem[addr][i] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_stage_lsu.sv
// rtl/mem_stage_lsu.sv - M-stage load/store unit and M/W pipeline register; optional MEM_STAGE_MISALIGN_CHECK_EN
module mem_stage_lsu
   import mem_stage_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int DEPTH = 1024
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            StallM,
   input  logic            FlushW,
   input  logic            RegWriteM,
   input  logic            MemWriteM,
   input  logic            ResultSrcM,
   input  logic [2:0]      Funct3M,
   input  logic [XLEN-1:0] ALUResultM,
   input  logic [XLEN-1:0] WriteDataM,
   input  logic [XLEN-1:0] PCPlus4M,
   input  logic [4:0]      RdM,
   output logic            RegWriteW,
   output logic            ResultSrcW,
   output logic [XLEN-1:0] ALUResultW,
   output logic [XLEN-1:0] ReadDataW,
   output logic [XLEN-1:0] PCPlus4W,
   output logic [4:0]      RdW,
   output logic            MisalignW
);

   localparam int IW = $clog2(DEPTH);

   logic [IW-1:0]   wordIdx;
   logic [1:0]      lane;
   accSize_t        size;
   logic            misalign;
   logic            memWe;
   logic [3:0]      laneWe;
   logic [XLEN-1:0] storeData;
   logic [XLEN-1:0] rawWord;
   logic [XLEN-1:0] loadValue;
   logic            unusedAddr;

   // Address bits above the word index are dropped so accesses wrap
   assign wordIdx    = ALUResultM[IW+1:2];
   assign lane       = ALUResultM[1:0];
   assign unusedAddr = ^ALUResultM[XLEN-1:IW+2];
   assign size       = accSize(Funct3M);

`ifdef MEM_STAGE_MISALIGN_CHECK_EN
   assign misalign = ((size == SZ_HALF) && lane[0]) || ((size == SZ_WORD) && (lane != 2'b00));
`else
   assign misalign = 1'b0;
`endif

   assign memWe  = MemWriteM && !StallM && !rst && !misalign;
   assign laneWe = memWe ? laneMask(size, lane) : 4'b0000;

   // Replicate store data so the addressed lanes see the low byte/halfword
   always_comb begin
      storeData = WriteDataM;
      case (size)
         SZ_BYTE: storeData = {4{WriteDataM[7:0]}};
         SZ_HALF: storeData = {2{WriteDataM[15:0]}};
         default: storeData = WriteDataM;
      endcase
   end

   dmem_bank #(
      .DEPTH (DEPTH),
      .AW    (IW)
   ) uBank (
      .clk   (clk),
      .addr  (wordIdx),
      .we    (laneWe),
      .wdata (storeData),
      .rdata (rawWord)
   );

   assign loadValue = extendLoad(Funct3M, rawWord, lane);

   // M/W register: reset beats flush, flush beats stall; flush still captures data as don't-care
   always_ff @(posedge clk) begin
      if (rst) begin
         RegWriteW  <= 1'b0;
         ResultSrcW <= 1'b0;
         MisalignW  <= 1'b0;
         ALUResultW <= '0;
         ReadDataW  <= '0;
         PCPlus4W   <= '0;
         RdW        <= '0;
      end else if (FlushW) begin
         RegWriteW  <= 1'b0;
         ResultSrcW <= 1'b0;
         MisalignW  <= 1'b0;
         ALUResultW <= ALUResultM;
         ReadDataW  <= loadValue;
         PCPlus4W   <= PCPlus4M;
         RdW        <= RdM;
      end else if (!StallM) begin
         RegWriteW  <= RegWriteM && !misalign;
         ResultSrcW <= ResultSrcM;
         MisalignW  <= misalign;
         ALUResultW <= ALUResultM;
         ReadDataW  <= loadValue;
         PCPlus4W   <= PCPlus4M;
         RdW        <= RdM;
      end
   end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// tb/tb_mem_stage_lsu.sv - randomized self-checking bench for mem_stage_lsu against a byte-array reference model
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        StallM, FlushW;
   logic        RegWriteM, MemWriteM, ResultSrcM;
   logic [2:0]  Funct3M;
   logic [31:0] ALUResultM, WriteDataM, PCPlus4M;
   logic [4:0]  RdM;
   logic        RegWriteW, ResultSrcW, MisalignW;
   logic [31:0] ALUResultW, ReadDataW, PCPlus4W;
   logic [4:0]  RdW;

   int nCmp = 0;
   int nBad = 0;

   // Reference state: byte-addressed memory image and expected W outputs
   logic [7:0]  mdl [4096];
   logic        eRw, eRs, eMis, eDataOk, eLoadOk;
   logic [31:0] eAlu, eRd, ePc;
   logic [4:0]  eDst;
   logic [31:0] saved;

   mem_stage_lsu dut (
      .clk        (clk),
      .rst        (rst),
      .StallM     (StallM),
      .FlushW     (FlushW),
      .RegWriteM  (RegWriteM),
      .MemWriteM  (MemWriteM),
      .ResultSrcM (ResultSrcM),
      .Funct3M    (Funct3M),
      .ALUResultM (ALUResultM),
      .WriteDataM (WriteDataM),
      .PCPlus4M   (PCPlus4M),
      .RdM        (RdM),
      .RegWriteW  (RegWriteW),
      .ResultSrcW (ResultSrcW),
      .ALUResultW (ALUResultW),
      .ReadDataW  (ReadDataW),
      .PCPlus4W   (PCPlus4W),
      .RdW        (RdW),
      .MisalignW  (MisalignW)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nCmp++;
      if (got !== exp) begin
         nBad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic int unsigned accBytes(input logic [2:0] f3);
      if (f3 == 3'b000 || f3 == 3'b100) return 1;
      if (f3 == 3'b001 || f3 == 3'b101) return 2;
      return 4;
   endfunction

   function automatic logic mdlMis(input logic [31:0] addr, input logic [2:0] f3);
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
      return (addr % accBytes(f3)) != 0;
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [31:0] mdlLoad(input logic [31:0] addr, input logic [2:0] f3);
      int unsigned n, base;
      logic [31:0] v;
      n    = accBytes(f3);
      base = addr % 4096;
      base = base - (base % n);
      v    = 0;
      for (int i = 0; i < int'(n); i++) v = v | (32'(mdl[base + i]) << (8 * i));
      if (f3 == 3'b000 && v[7])  v = v | 32'hFFFF_FF00;
      if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
      return v;
   endfunction

   task automatic mdlStore(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] wd);
      int unsigned n, base;
      n    = accBytes(f3);
      base = addr % 4096;
      base = base - (base % n);
      for (int i = 0; i < int'(n); i++) mdl[base + i] = wd[8*i +: 8];
   endtask

   task automatic drive(input logic rw, input logic mw, input logic rs, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd);
      RegWriteM  = rw;
      MemWriteM  = mw;
      ResultSrcM = rs;
      Funct3M    = f3;
      ALUResultM = addr;
      WriteDataM = wd;
      PCPlus4M   = $urandom;
      RdM        = 5'($urandom);
      StallM     = 1'b0;
      FlushW     = 1'b0;
      rst        = 1'b0;
   endtask

   // Advance one edge, update the model from the inputs present at that edge, compare all W outputs
   task automatic step();
      logic        mis;
      logic [31:0] ld;
      mis = mdlMis(ALUResultM, Funct3M);
      ld  = mdlLoad(ALUResultM, Funct3M);
      if (rst) begin
         eRw = 0; eRs = 0; eMis = 0; eAlu = 0; eRd = 0; ePc = 0; eDst = 0;
         eDataOk = 1; eLoadOk = 1;
      end else begin
         if (MemWriteM && !StallM && !mis) mdlStore(ALUResultM, Funct3M, WriteDataM);
         if (FlushW) begin
            eRw = 0; eRs = 0; eMis = 0; eDataOk = 0; eLoadOk = 0;
         end else if (!StallM) begin
            eRw = RegWriteM && !mis; eRs = ResultSrcM; eMis = mis;
            eAlu = ALUResultM; eRd = ld; ePc = PCPlus4M; eDst = RdM;
            eDataOk = 1; eLoadOk = !mis;
         end
      end
      @(posedge clk);
      #1;
      chk("RegWriteW", 32'(RegWriteW), 32'(eRw));
      chk("ResultSrcW", 32'(ResultSrcW), 32'(eRs));
      chk("MisalignW", 32'(MisalignW), 32'(eMis));
      if (eDataOk) begin
         chk("ALUResultW", ALUResultW, eAlu);
         chk("PCPlus4W", PCPlus4W, ePc);
         chk("RdW", 32'(RdW), 32'(eDst));
         if (eLoadOk) chk("ReadDataW", ReadDataW, eRd);
      end
   endtask

   initial begin
      drive(0, 0, 0, 3'b010, 0, 0);
      rst = 1'b1;
      step();
      step();
      chk("reset_rw", 32'(RegWriteW), 0);
      chk("reset_rd", ReadDataW, 0);

      // Fill the low 1 KiB with known words
      for (int w = 0; w < 256; w++) begin
         drive(0, 1, 0, 3'b010, 32'(w * 4), $urandom);
         step();
      end

      // SW then LW at 0x3E0
      drive(1, 1, 0, 3'b010, 32'h3E0, 32'hF000_00AC); step();
      drive(1, 0, 1, 3'b010, 32'h3E0, 0);             step();
      chk("lw_3e0", ReadDataW, 32'hF000_00AC);

      // SB 0x80 at 0x101
      saved = mdlLoad(32'h100, 3'b010);
      drive(0, 1, 0, 3'b000, 32'h101, {$urandom_range(0, 255), 24'h0000_80} | 32'h80); step();
      drive(1, 0, 1, 3'b000, 32'h101, 0); step();
      chk("lb_101", ReadDataW, 32'hFFFF_FF80);
      drive(1, 0, 1, 3'b100, 32'h101, 0); step();
      chk("lbu_101", ReadDataW, 32'h0000_0080);
      drive(1, 0, 1, 3'b010, 32'h100, 0); step();
      chk("lw_100", ReadDataW, (saved & 32'hFFFF_00FF) | 32'h0000_8000);

      // SH 0xBEEF at 0x22
      drive(0, 1, 0, 3'b001, 32'h22, 32'h1234_BEEF); step();
      drive(1, 0, 1, 3'b001, 32'h22, 0); step();
      chk("lh_22", ReadDataW, 32'hFFFF_BEEF);
      drive(1, 0, 1, 3'b101, 32'h22, 0); step();
      chk("lhu_22", ReadDataW, 32'h0000_BEEF);
      drive(1, 0, 1, 3'b010, 32'h20, 0); step();
      chk("lw_20_hi", 32'(ReadDataW[31:16]), 32'hBEEF);

      // Stall holds W and blocks the store; stall+flush clears RegWriteW
      saved = mdlLoad(32'h40, 3'b010);
      drive(1, 0, 1, 3'b010, 32'h3E0, 0); step();
      drive(1, 1, 0, 3'b010, 32'h40, 32'h1234_5678); StallM = 1'b1; step();
      chk("stall_hold", ReadDataW, 32'hF000_00AC);
      drive(1, 0, 1, 3'b010, 32'h40, 0); step();
      chk("stall_nowrite", ReadDataW, saved);
      drive(1, 0, 1, 3'b010, 32'h40, 0); StallM = 1'b1; FlushW = 1'b1; step();
      chk("stall_flush_rw", 32'(RegWriteW), 0);

      // Reset after a store: outputs clear, memory survives
      drive(0, 1, 0, 3'b010, 32'h70, 32'h0000_00F0); step();
      drive(1, 1, 1, 3'b010, 32'h70, 32'hDEAD_BEEF); rst = 1'b1; step();
      chk("rst_alu", ALUResultW, 0);
      chk("rst_pc", PCPlus4W, 0);
      drive(1, 0, 1, 3'b010, 32'h70, 0); step();
      chk("lw_70_after_rst", ReadDataW, 32'h0000_00F0);

      // Access at 0x42
      saved = mdlLoad(32'h40, 3'b010);
      drive(1, 0, 1, 3'b010, 32'h42, 0); step();
`ifdef MEM_STAGE_MISALIGN_CHECK_EN
      chk("mis_flag", 32'(MisalignW), 1);
      chk("mis_rw", 32'(RegWriteW), 0);
      drive(0, 1, 0, 3'b010, 32'h42, 32'hCAFE_F00D); step();
      drive(1, 0, 1, 3'b010, 32'h40, 0); step();
      chk("mis_nowrite", ReadDataW, saved);
`else
      chk("lw_42", ReadDataW, saved);
      chk("no_mis_flag", 32'(MisalignW), 0);
`endif

      // Address wrap above the array
      drive(0, 1, 0, 3'b010, 32'h0001_3084, 32'hA5A5_0F0F); step();
      drive(1, 0, 1, 3'b010, 32'h84, 0); step();
      chk("wrap_84", ReadDataW, 32'hA5A5_0F0F);

      // Random traffic
      for (int c = 0; c < 600; c++) begin
         logic [31:0] a;
         logic        isSt;
         a    = 32'($urandom_range(0, 1023));
         if ($urandom_range(0, 3) == 0) a = a | ($urandom << 12);
         isSt = ($urandom_range(0, 2) == 0);
         if (isSt) drive(1'($urandom), 1, 1'($urandom), 3'($urandom_range(0, 2)), a, $urandom);
         else      drive(1'($urandom), 0, 1'($urandom), 3'($urandom_range(0, 7)), a, $urandom);
         StallM = ($urandom_range(0, 5) == 0);
         FlushW = ($urandom_range(0, 7) == 0);
         rst    = ($urandom_range(0, 49) == 0);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule
